// File: rtl/fpu_norm_pkg.sv
// Shared defaults, result payload and width helper for the normalizer.
package fpu_norm_pkg;

    localparam int unsigned MAN_W_DEF = 8;
    localparam int unsigned EXP_W_DEF = 5;

    // Normalized result payload as handed to the rounding stage
    typedef struct packed {
        logic [MAN_W_DEF-1:0] man;
        logic [EXP_W_DEF-1:0] exp;
        logic                 zero;
        logic                 denorm;
    } norm_res_t;

    // Leading-zero count width: must hold the value MAN_W for an all-zero input
    function automatic int unsigned cnt_w(input int unsigned man_w);
        return $clog2(man_w + 1);
    endfunction

endpackage

// File: rtl/norm_lzc.sv
// Combinational leading-zero counter built from 8-bit groups.
module norm_lzc
    import fpu_norm_pkg::*;
#(
    parameter  int unsigned MAN_W = MAN_W_DEF,
    localparam int unsigned CNT_W = cnt_w(MAN_W)
) (
    input  logic [MAN_W-1:0] i_man,
    output logic [CNT_W-1:0] o_lzc
);

    localparam int unsigned NG = MAN_W / 8;

    logic [3:0]       w_glzc;
    logic             w_done;
    logic [CNT_W-1:0] w_cnt;

    // Leading zeros within one byte; 8 when the byte is empty
    function automatic logic [3:0] lzc8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd8;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) c = 4'(7 - i);
        end
        return c;
    endfunction

    // Accumulate whole empty groups from the MSB side, then the first non-empty group's count
    always_comb begin
        w_cnt  = '0;
        w_done = 1'b0;
        w_glzc = 4'd0;
        for (int g = NG - 1; g >= 0; g--) begin
            w_glzc = lzc8(i_man[g*8 +: 8]);
            if (!w_done) begin
                w_cnt = w_cnt + CNT_W'(w_glzc);
                if (w_glzc != 4'd8) w_done = 1'b1;
            end
        end
    end

    assign o_lzc = w_cnt;

endmodule

// File: rtl/norm_shift_pipe.sv
// Two-stage normalizer: stage 1 captures operand and LZC, stage 2 shifts and adjusts the exponent.
module norm_shift_pipe
    import fpu_norm_pkg::*;
#(
    parameter int unsigned MAN_W = MAN_W_DEF,
    parameter int unsigned EXP_W = EXP_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAN_W-1:0] in_man,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAN_W-1:0] out_man,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_zero,
    output logic             out_denorm
);

    localparam int unsigned CNT_W = cnt_w(MAN_W);
    localparam int unsigned CMP_W = (CNT_W > EXP_W) ? CNT_W : EXP_W;

    logic             r_s1_valid;
    logic [MAN_W-1:0] r_s1_man;
    logic [EXP_W-1:0] r_s1_exp;
    logic [CNT_W-1:0] r_s1_lzc;

    logic             r_s2_valid;
    logic [MAN_W-1:0] r_out_man;
    logic [EXP_W-1:0] r_out_exp;
    logic             r_out_zero;
    logic             r_out_denorm;

    logic             w_s1_adv;
    logic             w_s2_adv;
    logic [CNT_W-1:0] w_lzc;
    logic [CMP_W-1:0] w_lzc_x;
    logic [CMP_W-1:0] w_exp_x;
    logic [MAN_W-1:0] w_nxt_man;
    logic [EXP_W-1:0] w_nxt_exp;
    logic             w_nxt_zero;
    logic             w_nxt_denorm;

    assign w_s2_adv = ~r_s2_valid | out_ready;
    assign w_s1_adv = ~r_s1_valid | w_s2_adv;
    assign in_ready = w_s1_adv;

    norm_lzc #(.MAN_W(MAN_W)) u_lzc (
        .i_man (in_man),
        .o_lzc (w_lzc)
    );

    // Stage 1: capture operand and its leading-zero count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_man   <= '0;
            r_s1_exp   <= '0;
            r_s1_lzc   <= '0;
        end else begin
            if (flush)         r_s1_valid <= 1'b0;
            else if (w_s1_adv) r_s1_valid <= in_valid;
            if (!flush && w_s1_adv && in_valid) begin
                r_s1_man <= in_man;
                r_s1_exp <= in_exp;
                r_s1_lzc <= w_lzc;
            end
        end
    end

    assign w_lzc_x = CMP_W'(r_s1_lzc);
    assign w_exp_x = CMP_W'(r_s1_exp);

    // Stage 2 datapath: shift limited so the exponent never goes below the denormal floor
    always_comb begin
        w_nxt_man    = r_s1_man;
        w_nxt_exp    = '0;
        w_nxt_zero   = 1'b0;
        w_nxt_denorm = 1'b0;
        if (r_s1_man == '0) begin
            w_nxt_man  = '0;
            w_nxt_zero = 1'b1;
        end else if (w_lzc_x < w_exp_x) begin
            w_nxt_man = r_s1_man << w_lzc_x;
            w_nxt_exp = EXP_W'(w_exp_x - w_lzc_x);
        end else if (w_exp_x != '0) begin
            w_nxt_man    = r_s1_man << (w_exp_x - CMP_W'(1));
            w_nxt_denorm = 1'b1;
        end else begin
            w_nxt_denorm = 1'b1;
        end
    end

    // Stage 2: output registers, held while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid   <= 1'b0;
            r_out_man    <= '0;
            r_out_exp    <= '0;
            r_out_zero   <= 1'b0;
            r_out_denorm <= 1'b0;
        end else begin
            if (flush)         r_s2_valid <= 1'b0;
            else if (w_s2_adv) r_s2_valid <= r_s1_valid;
            if (!flush && w_s2_adv && r_s1_valid) begin
                r_out_man    <= w_nxt_man;
                r_out_exp    <= w_nxt_exp;
                r_out_zero   <= w_nxt_zero;
                r_out_denorm <= w_nxt_denorm;
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_man    = r_out_man;
    assign out_exp    = r_out_exp;
    assign out_zero   = r_out_zero;
    assign out_denorm = r_out_denorm;

endmodule

// File: tb/tb_norm_shift_pipe.sv
// Directed bench for norm_shift_pipe with MAN_W=8, EXP_W=5.
module tb_norm_shift_pipe;
    import fpu_norm_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_man;
    logic [4:0] in_exp;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_man;
    logic [4:0] out_exp;
    logic       out_zero;
    logic       out_denorm;

    int checks = 0;
    int errors = 0;
    norm_res_t exp_r;
    norm_res_t act_r;

    norm_shift_pipe #(.MAN_W(8), .EXP_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_man     (in_man),
        .in_exp     (in_exp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_man    (out_man),
        .out_exp    (out_exp),
        .out_zero   (out_zero),
        .out_denorm (out_denorm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign act_r = '{man: out_man, exp: out_exp, zero: out_zero, denorm: out_denorm};

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] m, input logic [4:0] e);
        in_valid = v;
        in_man   = m;
        in_exp   = e;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 8'h00, 5'd0);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        exp_r = '{man: 8'h00, exp: 5'd0, zero: 1'b0, denorm: 1'b0};
        checks++;
        if (act_r !== exp_r) begin errors++; $display("FAIL reset_data: got %h want %h", act_r, exp_r); end
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_normal();
        drive(1'b1, 8'b0001_0110, 5'd10);
        tick();
        drive(1'b0, 8'h00, 5'd0);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL normal_early: got %b want 0", out_valid); end
        tick();
        exp_r = '{man: 8'b1011_0000, exp: 5'd7, zero: 1'b0, denorm: 1'b0};
        checks++;
        if (out_valid !== 1'b1 || act_r !== exp_r) begin
            errors++; $display("FAIL normal_result: got v=%b %h want v=1 %h", out_valid, act_r, exp_r);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL normal_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_zero();
        drive(1'b1, 8'h00, 5'd12);
        tick();
        drive(1'b1, 8'h80, 5'd1);
        tick();
        drive(1'b0, 8'h00, 5'd0);
        exp_r = '{man: 8'h00, exp: 5'd0, zero: 1'b1, denorm: 1'b0};
        checks++;
        if (out_valid !== 1'b1 || act_r !== exp_r) begin
            errors++; $display("FAIL zero_result: got v=%b %h want v=1 %h", out_valid, act_r, exp_r);
        end
        tick();
        exp_r = '{man: 8'h80, exp: 5'd1, zero: 1'b0, denorm: 1'b0};
        checks++;
        if (out_valid !== 1'b1 || act_r !== exp_r) begin
            errors++; $display("FAIL zero_normed: got v=%b %h want v=1 %h", out_valid, act_r, exp_r);
        end
        tick();
    endtask

    task automatic test_denorm();
        drive(1'b1, 8'b0000_0101, 5'd3);
        tick();
        drive(1'b1, 8'h05, 5'd0);
        tick();
        drive(1'b0, 8'h00, 5'd0);
        exp_r = '{man: 8'b0001_0100, exp: 5'd0, zero: 1'b0, denorm: 1'b1};
        checks++;
        if (out_valid !== 1'b1 || act_r !== exp_r) begin
            errors++; $display("FAIL denorm_floor: got v=%b %h want v=1 %h", out_valid, act_r, exp_r);
        end
        tick();
        exp_r = '{man: 8'h05, exp: 5'd0, zero: 1'b0, denorm: 1'b1};
        checks++;
        if (out_valid !== 1'b1 || act_r !== exp_r) begin
            errors++; $display("FAIL denorm_exp0: got v=%b %h want v=1 %h", out_valid, act_r, exp_r);
        end
        tick();
    endtask

    // lzc == exp-1 still normalizes; lzc == exp hits the floor
    task automatic test_back_to_back();
        norm_res_t exp_q[3];
        exp_q[0] = '{man: 8'h80, exp: 5'd1, zero: 1'b0, denorm: 1'b0};
        exp_q[1] = '{man: 8'h40, exp: 5'd0, zero: 1'b0, denorm: 1'b1};
        exp_q[2] = '{man: 8'hFF, exp: 5'd31, zero: 1'b0, denorm: 1'b0};
        drive(1'b1, 8'h01, 5'd8);  tick();
        drive(1'b1, 8'h20, 5'd2);  tick();
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive(1'b1, 8'hFF, 5'd31);
            else        drive(1'b0, 8'h00, 5'd0);
            checks++;
            if (out_valid !== 1'b1 || act_r !== exp_q[i]) begin
                errors++; $display("FAIL b2b_%0d: got v=%b %h want v=1 %h", i, out_valid, act_r, exp_q[i]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        norm_res_t b1, b2, b3;
        b1 = '{man: 8'hB0, exp: 5'd7,  zero: 1'b0, denorm: 1'b0};
        b2 = '{man: 8'h80, exp: 5'd13, zero: 1'b0, denorm: 1'b0};
        b3 = '{man: 8'h80, exp: 5'd1,  zero: 1'b0, denorm: 1'b0};
        out_ready = 1'b0;
        drive(1'b1, 8'h16, 5'd10); tick();
        drive(1'b1, 8'h01, 5'd20); tick();
        drive(1'b1, 8'h40, 5'd2);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || act_r !== b1) begin
                errors++; $display("FAIL bp_hold_%0d: got v=%b rdy=%b %h want v=1 rdy=0 %h",
                                   i, out_valid, in_ready, act_r, b1);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        tick();
        drive(1'b0, 8'h00, 5'd0);
        checks++;
        if (out_valid !== 1'b1 || act_r !== b2) begin
            errors++; $display("FAIL bp_second: got v=%b %h want v=1 %h", out_valid, act_r, b2);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || act_r !== b3) begin
            errors++; $display("FAIL bp_third: got v=%b %h want v=1 %h", out_valid, act_r, b3);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, 8'h16, 5'd10); tick();
        drive(1'b1, 8'h01, 5'd20); tick();
        drive(1'b0, 8'h00, 5'd0);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_full: got %b want 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_man !== 8'h00) begin
            errors++; $display("FAIL ar_drop: got v=%b man=%h want v=0 man=00", out_valid, out_man);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ar_in_ready: got %b want 1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_stale_%0d: got %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 8'h16, 5'd10); tick();
        drive(1'b1, 8'h01, 5'd20); tick();
        drive(1'b1, 8'h40, 5'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 8'h00, 5'd0);
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        checks++;
        if (out_man !== 8'hB0) begin errors++; $display("FAIL flush_data_kept: got %h want b0", out_man); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop_%0d: got %b want 0", i, out_valid); end
        end
        drive(1'b1, 8'h01, 5'd5); tick();
        drive(1'b0, 8'h00, 5'd0); tick();
        exp_r = '{man: 8'h10, exp: 5'd0, zero: 1'b0, denorm: 1'b1};
        checks++;
        if (out_valid !== 1'b1 || act_r !== exp_r) begin
            errors++; $display("FAIL flush_after: got v=%b %h want v=1 %h", out_valid, act_r, exp_r);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_zero();
        test_denorm();
        test_back_to_back();
        test_backpressure();
        test_async_reset();
        test_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
